// File: rtl/ofmap_writeback_pkg.sv
//============================================================================
// Module : ofmap_writeback_pkg
// Brief  : Shared FSM encodings, layout codes and default widths for the
//          output-feature-map write-back engine.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

package ofmap_writeback_pkg;

    localparam int DEF_TENSOR_W   = 8;
    localparam int DEF_KERNEL_W   = 4;
    localparam int DEF_STRIDE_W   = 4;
    localparam int DEF_KNUM_W     = 8;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int       ST_W      = 2;
    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_SETUP  = 2'd1;
    localparam logic [ST_W-1:0] ST_RUN    = 2'd2;
    localparam logic [ST_W-1:0] ST_FINISH = 2'd3;

    localparam logic LAYOUT_CHW = 1'b0;
    localparam logic LAYOUT_HWC = 1'b1;

endpackage : ofmap_writeback_pkg

`default_nettype wire

// File: rtl/ofmap_writeback_wb_fifo.sv
//============================================================================
// Module : wb_fifo
// Brief  : Synchronous FIFO buffering {address, data} write requests.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module wb_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    // A push while full is only taken when the head leaves in the same cycle.
    assign w_push  = push_i && (!full_o || pop_i);
    assign w_pop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (w_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule : wb_fifo

`default_nettype wire

// File: rtl/ofmap_writeback.sv
//============================================================================
// Module : ofmap_writeback
// Brief  : Buffers the kernel-major GEMM result stream and writes it back to
//          memory in CHW or HWC layout, pulsing done after the last write.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module ofmap_writeback
    import ofmap_writeback_pkg::*;
#(
    parameter int TENSOR_W   = DEF_TENSOR_W,
    parameter int KERNEL_W   = DEF_KERNEL_W,
    parameter int STRIDE_W   = DEF_STRIDE_W,
    parameter int KNUM_W     = DEF_KNUM_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [TENSOR_W-1:0] tensor_size_i,
    input  logic [KERNEL_W-1:0] kernel_size_i,
    input  logic [STRIDE_W-1:0] stride_i,
    input  logic [KNUM_W-1:0]   kernel_nums_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic                layout_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [DATA_W-1:0]   in_data_i,
    output logic                mem_wr_en_o,
    input  logic                mem_wr_ready_i,
    output logic [ADDR_W-1:0]   mem_wr_addr_o,
    output logic [DATA_W-1:0]   mem_wr_data_o,
    output logic [TENSOR_W-1:0] out_size_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int PIX_W = 2 * TENSOR_W;
    localparam int CNT_W = PIX_W + KNUM_W;

    logic [ST_W-1:0]     state_q, state_d;
    logic [TENSOR_W-1:0] tsize_q;
    logic [KERNEL_W-1:0] ksize_q;
    logic [STRIDE_W-1:0] stride_q;
    logic [KNUM_W-1:0]   knum_q;
    logic [ADDR_W-1:0]   base_q;
    logic                layout_q;
    logic                err_q;
    logic [TENSOR_W-1:0] rem_q;
    logic [TENSOR_W-1:0] quo_q;
    logic [TENSOR_W-1:0] out_q;
    logic [PIX_W-1:0]    out_sq_q;
    logic [CNT_W-1:0]    total_q;
    logic [CNT_W-1:0]    acc_q;
    logic [CNT_W-1:0]    wr_q;
    logic [PIX_W-1:0]    pix_q;
    logic [KNUM_W-1:0]   kidx_q;
    logic [ADDR_W-1:0]   pix_base_q;
    logic [ADDR_W-1:0]   chw_off_q;

    logic [TENSOR_W-1:0] w_stride_eff;
    logic                w_cfg_bad;
    logic                w_div_step;
    logic [TENSOR_W-1:0] w_out_next;
    logic [PIX_W-1:0]    w_out_sq;
    logic [CNT_W-1:0]    w_total;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [ADDR_W-1:0]   w_push_addr;

    assign w_stride_eff = (stride_q == '0) ? TENSOR_W'(1) : TENSOR_W'(stride_q);
    assign w_cfg_bad    = (tsize_q < TENSOR_W'(ksize_q)) || (ksize_q == '0) || (knum_q == '0);
    assign w_div_step   = (rem_q >= w_stride_eff);
    assign w_out_next   = quo_q + TENSOR_W'(1);
    assign w_out_sq     = PIX_W'(w_out_next) * PIX_W'(w_out_next);
    assign w_total      = CNT_W'(w_out_sq) * CNT_W'(knum_q);

    assign w_push = in_valid_i && in_ready_o;
    assign w_pop  = mem_wr_en_o && mem_wr_ready_i;

    // CHW is a plain running index; HWC strides by kernel_nums per pixel.
    assign w_push_addr = (layout_q == LAYOUT_HWC) ? (base_q + pix_base_q + ADDR_W'(kidx_q))
                                                  : (base_q + chw_off_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_SETUP;
            ST_SETUP: begin
                if (w_cfg_bad) begin
                    state_d = ST_FINISH;
                end else if (!w_div_step) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:    if (w_pop && (wr_q == total_q - CNT_W'(1))) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == ST_SETUP) || (state_q == ST_RUN);
        done_o     = (state_q == ST_FINISH);
        err_o      = (state_q == ST_FINISH) && err_q;
        in_ready_o = (state_q == ST_RUN) && !w_full && (acc_q < total_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tsize_q    <= '0;
            ksize_q    <= '0;
            stride_q   <= '0;
            knum_q     <= '0;
            base_q     <= '0;
            layout_q   <= LAYOUT_CHW;
            err_q      <= 1'b0;
            rem_q      <= '0;
            quo_q      <= '0;
            out_q      <= '0;
            out_sq_q   <= '0;
            total_q    <= '0;
            acc_q      <= '0;
            wr_q       <= '0;
            pix_q      <= '0;
            kidx_q     <= '0;
            pix_base_q <= '0;
            chw_off_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        tsize_q    <= tensor_size_i;
                        ksize_q    <= kernel_size_i;
                        stride_q   <= stride_i;
                        knum_q     <= kernel_nums_i;
                        base_q     <= base_addr_i;
                        layout_q   <= layout_i;
                        err_q      <= 1'b0;
                        rem_q      <= tensor_size_i - TENSOR_W'(kernel_size_i);
                        quo_q      <= '0;
                        out_q      <= '0;
                        acc_q      <= '0;
                        wr_q       <= '0;
                        pix_q      <= '0;
                        kidx_q     <= '0;
                        pix_base_q <= '0;
                        chw_off_q  <= '0;
                    end
                end
                ST_SETUP: begin
                    if (w_cfg_bad) begin
                        err_q <= 1'b1;
                    end else if (w_div_step) begin
                        rem_q <= rem_q - w_stride_eff;
                        quo_q <= quo_q + TENSOR_W'(1);
                    end else begin
                        out_q    <= w_out_next;
                        out_sq_q <= w_out_sq;
                        total_q  <= w_total;
                    end
                end
                ST_RUN: begin
                    if (w_push) begin
                        acc_q     <= acc_q + CNT_W'(1);
                        chw_off_q <= chw_off_q + ADDR_W'(1);
                        if (pix_q == out_sq_q - PIX_W'(1)) begin
                            pix_q      <= '0;
                            kidx_q     <= kidx_q + KNUM_W'(1);
                            pix_base_q <= '0;
                        end else begin
                            pix_q      <= pix_q + PIX_W'(1);
                            pix_base_q <= pix_base_q + ADDR_W'(knum_q);
                        end
                    end
                    if (w_pop) begin
                        wr_q <= wr_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_size_o = out_q;

    wb_fifo #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .wdata_i ({w_push_addr, in_data_i}),
        .pop_i   (w_pop),
        .rdata_o ({mem_wr_addr_o, mem_wr_data_o}),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign mem_wr_en_o = !w_empty;

endmodule : ofmap_writeback

`default_nettype wire

// File: tb/tb_ofmap_writeback.sv
//============================================================================
// Module : tb_ofmap_writeback
// Brief  : Randomized self-checking bench for ofmap_writeback against a
//          loop-based address/ordering reference model.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_ofmap_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [7:0]  tensor_size_i;
    logic [3:0]  kernel_size_i;
    logic [3:0]  stride_i;
    logic [7:0]  kernel_nums_i;
    logic [15:0] base_addr_i;
    logic        layout_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        mem_wr_en_o;
    logic        mem_wr_ready_i;
    logic [15:0] mem_wr_addr_o;
    logic [31:0] mem_wr_data_o;
    logic [7:0]  out_size_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int total_cnt = 0;
    int bad_cnt   = 0;

    always #5 clk = ~clk;

    ofmap_writeback dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .tensor_size_i  (tensor_size_i),
        .kernel_size_i  (kernel_size_i),
        .stride_i       (stride_i),
        .kernel_nums_i  (kernel_nums_i),
        .base_addr_i    (base_addr_i),
        .layout_i       (layout_i),
        .in_valid_i     (in_valid_i),
        .in_ready_o     (in_ready_o),
        .in_data_i      (in_data_i),
        .mem_wr_en_o    (mem_wr_en_o),
        .mem_wr_ready_i (mem_wr_ready_i),
        .mem_wr_addr_o  (mem_wr_addr_o),
        .mem_wr_data_o  (mem_wr_data_o),
        .out_size_o     (out_size_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    task automatic chk_eq(input string tag, input longint got, input longint exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string ctx);
        chk_eq({ctx, "_in_ready"}, longint'(in_ready_o), 0);
        chk_eq({ctx, "_wr_en"},    longint'(mem_wr_en_o), 0);
        chk_eq({ctx, "_busy"},     longint'(busy_o), 0);
        chk_eq({ctx, "_done"},     longint'(done_o), 0);
        chk_eq({ctx, "_err"},      longint'(err_o), 0);
        chk_eq({ctx, "_addr"},     longint'(mem_wr_addr_o), 0);
        chk_eq({ctx, "_data"},     longint'(mem_wr_data_o), 0);
        chk_eq({ctx, "_out_size"}, longint'(out_size_o), 0);
    endtask

    // abort_at >= 0: reset the DUT once that many writes have completed.
    task automatic run_job(input int t, input int k, input int s, input int kn,
                           input int base, input int lay, input int rdy_pct,
                           input int stall_at, input int abort_at);
        logic [15:0] exp_addr[$];
        logic [31:0] acc_data[$];
        logic [15:0] av;
        logic [15:0] head_addr;
        logic [31:0] head_data;
        bit   valid, finished, pend_done, seen_ready, in_stall, head_rec;
        int   seff, osz, total, wr, acc, setup_cnt, stall_left, seen_en;

        valid = (t >= k) && (k != 0) && (kn != 0);
        seff  = (s == 0) ? 1 : s;
        osz   = valid ? ((t - k) / seff + 1) : 0;
        total = osz * osz * kn;
        for (int kk = 0; kk < kn && valid; kk++) begin
            for (int p = 0; p < osz * osz; p++) begin
                av = 16'((lay != 0) ? (base + p * kn + kk) : (base + kk * osz * osz + p));
                exp_addr.push_back(av);
            end
        end

        finished = 0; pend_done = 0; seen_ready = 0; head_rec = 0;
        wr = 0; acc = 0; setup_cnt = 0; seen_en = 0;
        stall_left = (stall_at >= 0) ? 10 : 0;

        @(negedge clk);
        start_i        = 1'b1;
        tensor_size_i  = 8'(t);
        kernel_size_i  = 4'(k);
        stride_i       = 4'(s);
        kernel_nums_i  = 8'(kn);
        base_addr_i    = 16'(base);
        layout_i       = (lay != 0);
        in_valid_i     = 1'b0;
        mem_wr_ready_i = 1'b0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (stall_left > 0 && wr >= stall_at) begin
                in_valid_i     = 1'b1;
                mem_wr_ready_i = 1'b0;
                stall_left--;
                in_stall       = 1;
            end else begin
                in_valid_i     = ($urandom % 4) != 0;
                mem_wr_ready_i = ($urandom % 100) < rdy_pct;
                in_stall       = 0;
            end
            in_data_i = $urandom;
            #1;
            if (cyc == 0) chk_eq("busy_rise", longint'(busy_o), 1);
            if (!seen_ready) begin
                if (in_ready_o) seen_ready = 1;
                else if (busy_o) setup_cnt++;
            end
            if (pend_done) begin
                chk_eq("done_after_last", longint'(done_o), 1);
                chk_eq("err_on_valid", longint'(err_o), 0);
                chk_eq("busy_drop", longint'(busy_o), 0);
                finished = 1;
                break;
            end
            if (done_o) begin
                chk_eq(valid ? "done_early_writes" : "err_writes", wr, total);
                chk_eq("err_with_done", longint'(err_o), valid ? 0 : 1);
                chk_eq("no_wr_en_on_err", seen_en, 0);
                finished = 1;
                break;
            end
            if (mem_wr_en_o) seen_en++;
            if (in_stall && mem_wr_en_o) begin
                if (!head_rec) begin
                    head_addr = mem_wr_addr_o;
                    head_data = mem_wr_data_o;
                    head_rec  = 1;
                end else begin
                    chk_eq("stall_head_addr", longint'(mem_wr_addr_o), longint'(head_addr));
                    chk_eq("stall_head_data", longint'(mem_wr_data_o), longint'(head_data));
                end
                if (stall_left == 0) begin
                    chk_eq("stall_in_ready_low", longint'(in_ready_o), 0);
                    chk_eq("stall_wr_en", longint'(mem_wr_en_o), 1);
                end
            end
            if (mem_wr_en_o && mem_wr_ready_i) begin
                if (wr < total && wr < acc_data.size()) begin
                    chk_eq("wr_addr", longint'(mem_wr_addr_o), longint'(exp_addr[wr]));
                    chk_eq("wr_data", longint'(mem_wr_data_o), longint'(acc_data[wr]));
                end else begin
                    chk_eq("extra_write", wr, total);
                end
                wr++;
                if (wr == total) pend_done = 1;
            end
            if (in_valid_i && in_ready_o) begin
                if (acc >= total) chk_eq("accept_overrun", acc, total - 1);
                acc_data.push_back(in_data_i);
                acc++;
            end
            if (abort_at >= 0 && wr == abort_at) begin
                @(negedge clk);
                rst            = 1'b1;
                in_valid_i     = 1'b0;
                mem_wr_ready_i = 1'b0;
                #1;
                chk_idle_outputs("abort_rst");
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk_idle_outputs("abort_release");
                return;
            end
        end

        if (!finished) begin
            chk_eq("timeout", 0, 1);
            return;
        end
        if (valid) begin
            chk_eq("out_size", longint'(out_size_o), osz);
            chk_eq("setup_cycles", setup_cnt, osz);
        end else begin
            chk_eq("setup_cycles_err", setup_cnt, 1);
        end
        in_valid_i     = 1'b0;
        mem_wr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk_eq("done_once", longint'(done_o), 0);
        end
    endtask

    initial begin
        int rt, rk;
        rst            = 1'b1;
        start_i        = 1'b0;
        tensor_size_i  = '0;
        kernel_size_i  = '0;
        stride_i       = '0;
        kernel_nums_i  = '0;
        base_addr_i    = '0;
        layout_i       = 1'b0;
        in_valid_i     = 1'b0;
        in_data_i      = '0;
        mem_wr_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_idle_outputs("reset");
        rst = 1'b0;

        run_job(5, 3, 1, 2, 16'h100, 0, 100, -1, -1);
        run_job(5, 3, 1, 2, 16'h100, 1, 100, -1, -1);
        run_job(7, 3, 2, 1, 16'h200, 0, 100, -1, -1);
        run_job(2, 3, 1, 1, 16'h000, 0, 100, -1, -1);
        run_job(5, 0, 1, 1, 16'h000, 0, 100, -1, -1);
        run_job(5, 3, 1, 0, 16'h000, 1, 100, -1, -1);
        run_job(5, 3, 1, 2, 16'h400, 1, 100, 5, -1);
        run_job(5, 3, 1, 2, 16'h300, 0, 100, -1, 5);
        run_job(5, 3, 1, 2, 16'h300, 0, 70, -1, -1);
        run_job(6, 2, 0, 3, 16'hFFF0, 1, 60, -1, -1);
        for (int j = 0; j < 6; j++) begin
            rt = $urandom_range(3, 12);
            rk = $urandom_range(1, (rt > 15) ? 15 : rt);
            run_job(rt, rk, $urandom_range(0, 3), $urandom_range(1, 4),
                    $urandom_range(0, 65535), $urandom_range(0, 1),
                    $urandom_range(40, 100), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_ofmap_writeback

`default_nettype wire
